vco_sweep_ctrl: RTL and testbench
=================================

Name: vco_sweep_ctrl

Overview:
Upstream control stage for the vco block on the Nano20K board. It generates the 8-bit tuning word that drives vco i_data, so the board sweeps frequency instead of using a constant. Each tuning value is held for a programmable dwell time. Sweep modes are hold, single ramp, looping ramp and triangle, with start/stop control and status outputs.

Parameters:
DWELL_W, 24, width of the dwell counter. The default gives about 0.6 s per step at 27 MHz.
DATA_W, 8, tuning word width. Must match vco i_data.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous reset, active-high
i_start  in  1  start pulse; sampled only in IDLE
i_stop  in  1  abort; wins over i_start
i_mode  in  2  00 HOLD, 01 RAMP_ONCE, 10 RAMP_LOOP, 11 TRIANGLE
i_lo  in  DATA_W  lower sweep bound
i_hi  in  DATA_W  upper sweep bound
i_step  in  DATA_W  increment per step; 0 is treated as 1
i_dwell  in  DWELL_W  each value is held for i_dwell+1 cycles
o_data  out  DATA_W  tuning word to vco i_data
o_data_valid  out  1  1-cycle pulse whenever o_data is written
o_busy  out  1  high while sweeping
o_done  out  1  1-cycle pulse at RAMP_ONCE completion
o_err  out  1  1-cycle pulse when a start is rejected (i_lo > i_hi)

Behaviour:
- Reset (synchronous, active-high, one clock):
  - state = IDLE, dir = UP.
  - o_data = 0; o_data_valid, o_busy, o_done and o_err all 0.
  - Asserting reset mid-sweep returns everything to these values on the next edge.
- States: IDLE, RUN, HOLD.
- IDLE:
  - o_data keeps its last value.
  - i_start at edge k with i_lo <= i_hi:
    - latch mode, lo, hi, step (0 becomes 1) and dwell;
    - at k+1: o_data = lo, o_data_valid = 1, o_busy = 1, dwell counter = dwell, dir = UP;
    - next state is HOLD if mode = 00, else RUN.
  - i_start with i_lo > i_hi: o_err = 1 at k+1, stay in IDLE, o_data unchanged.
- Inputs are sampled only at start. Changes to inputs during a sweep are ignored until the next start.
- i_start while busy is ignored.
- RUN:
  - The counter decrements each cycle. When it reaches 0 it reloads with dwell and a step occurs on that same edge.
  - Timing: the value written at cycle t is held through cycle t+dwell; the next value appears at t+dwell+1.
  - UP step, o_data < hi: o_data = min(o_data+step, hi). Compute with DATA_W+1 bits so there is no wrap.
  - UP step, o_data == hi, by mode:
    - RAMP_ONCE: o_done = 1, o_busy = 0, state = IDLE, o_data stays at hi, no valid pulse;
    - RAMP_LOOP: o_data = lo;
    - TRIANGLE: dir = DOWN, o_data = max(hi-step, lo).
  - DOWN step (TRIANGLE only):
    - o_data > lo: o_data = max(o_data-step, lo), computed with borrow detection and no underflow;
    - o_data == lo: dir = UP, o_data = min(lo+step, hi).
  - Degenerate lo == hi in TRIANGLE: o_data stays at lo and o_data_valid pulses on every step.
  - Every o_data write in RUN pulses o_data_valid for one cycle.
- HOLD: o_data = lo, o_busy = 1. Leaves only via i_stop or reset.
- i_stop in RUN or HOLD:
  - at the next edge: state = IDLE, o_busy = 0, o_data holds its current value;
  - no o_done pulse and no valid pulse.
  - i_stop in IDLE has no effect.
- Simultaneous events: i_stop and i_start in the same cycle in IDLE means stop wins; no start, no o_err. Reset overrides everything.
- o_done and o_busy falling occur on the same edge.

Decomposition:
- Package vco_sweep_pkg holds:
  - mode constants MODE_HOLD, MODE_RAMP_ONCE, MODE_RAMP_LOOP, MODE_TRIANGLE;
  - the state encoding (IDLE, RUN, HOLD);
  - the dir encoding (UP, DOWN).
- Sub-module vco_dwell_timer:
  - inputs: load, value, enable;
  - output: tick, asserted when the count reaches 0; it auto-reloads on tick.
- vco_sweep_ctrl contains the FSM and the saturating step arithmetic.

Test Plan:
- RAMP_ONCE, lo=10, hi=20, step=4, dwell=1, start at cycle 0 -> o_data is 10, 14, 18, 20, each for 2 cycles starting at cycle 1. o_done pulses at cycle 9, o_busy falls at 9, and o_data stays 20.
- TRIANGLE, lo=250, hi=255, step=4, dwell=0 -> o_data is 250, 254, 255, 251, 250, 254, … with no 8-bit wrap and a valid pulse every cycle.
- RAMP_LOOP, lo=0, hi=8, step=0, dwell=2 -> step is treated as 1; o_data is 0..8 then 0, each value held for 3 cycles, and o_busy stays high.
- Start with lo=30, hi=20 -> o_err pulses for 1 cycle, o_busy stays 0, o_data unchanged. The same cycle with i_stop=1 -> no o_err.
- HOLD, lo=0x5A, then i_stop after 100 cycles -> o_data = 0x5A throughout, o_busy drops on the edge after stop, no o_done.
- Reset asserted mid-RAMP_LOOP, then i_start while busy -> after reset all outputs are 0 and state is IDLE. A start issued while busy is ignored: o_data does not return to lo.

Source files
------------

// File: rtl/vco_sweep_pkg.sv
// -----------------------------------------------------------------------------
// vco_sweep_pkg
// Shared definitions for the VCO sweep controller:
//   - sweep mode codes as presented on i_mode
//   - controller state encoding (IDLE, RUN, HOLD)
//   - sweep direction encoding (UP, DOWN)
// -----------------------------------------------------------------------------
package vco_sweep_pkg;

    localparam logic [1:0] MODE_HOLD      = 2'b00;
    localparam logic [1:0] MODE_RAMP_ONCE = 2'b01;
    localparam logic [1:0] MODE_RAMP_LOOP = 2'b10;
    localparam logic [1:0] MODE_TRIANGLE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/vco_dwell_timer.sv
// -----------------------------------------------------------------------------
// vco_dwell_timer
// Down-counter that paces the sweep. A load presets the count and remembers
// the reload value; while enabled the count decrements and, on reaching zero,
// o_tick is asserted and the count reloads on that same edge.
// Ports:
//   i_clk     system clock
//   i_reset   synchronous active-high reset
//   i_load    preset count and reload value from i_value
//   i_value   dwell value (each step lasts i_value+1 enabled cycles)
//   i_enable  count while high
//   o_tick    high in the cycle the count is zero (and enabled)
// -----------------------------------------------------------------------------
module vco_dwell_timer
    import vco_sweep_pkg::*;
#(
    parameter int DWELL_W = 24
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_value,
    input  logic               i_enable,
    output logic               o_tick
);

    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_reload;

    assign o_tick = i_enable && (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_reload <= '0;
        end else if (i_load) begin
            r_cnt    <= i_value;
            r_reload <= i_value;
        end else if (o_tick) begin
            r_cnt <= r_reload;
        end else if (i_enable) begin
            r_cnt <= r_cnt - DWELL_W'(1);
        end
    end

endmodule

// File: rtl/vco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// vco_sweep_ctrl
// Generates the tuning word for the VCO. Each value is held for dwell+1
// cycles; modes are hold, single ramp, looping ramp and triangle.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start               start pulse (accepted only when idle)
//   i_stop                abort; has priority over i_start
//   i_mode                00 HOLD, 01 RAMP_ONCE, 10 RAMP_LOOP, 11 TRIANGLE
//   i_lo, i_hi            sweep bounds (start rejected when i_lo > i_hi)
//   i_step                increment per step (0 treated as 1)
//   i_dwell               hold time per value minus one
//   o_data                tuning word
//   o_data_valid          one-cycle pulse on every o_data write
//   o_busy                high while sweeping or holding
//   o_done                one-cycle pulse when a single ramp completes
//   o_err                 one-cycle pulse on a rejected start
// -----------------------------------------------------------------------------
module vco_sweep_ctrl
    import vco_sweep_pkg::*;
#(
    parameter int DWELL_W = 24,
    parameter int DATA_W  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [1:0]         i_mode,
    input  logic [DATA_W-1:0]  i_lo,
    input  logic [DATA_W-1:0]  i_hi,
    input  logic [DATA_W-1:0]  i_step,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_data_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    // Sweep parameters captured at start; later input changes are ignored.
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_step;

    state_t            r_state;
    dir_t              r_dir;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_done;
    logic              r_err;

    state_t            w_state_next;
    dir_t              w_dir_next;
    logic [DATA_W-1:0] w_data_next;
    logic              w_valid_next;
    logic              w_done_next;
    logic              w_err_next;
    logic              w_accept;
    logic              w_tick;
    logic [DATA_W-1:0] w_step_eff;

    // min(a+b, ceil) evaluated one bit wider so the sum never wraps.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] ceil);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, ceil})
            return ceil;
        return s[DATA_W-1:0];
    endfunction

    // max(a-b, floor); the extra MSB is the borrow, which forces the floor.
    function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] floor);
        logic [DATA_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[DATA_W] || (d[DATA_W-1:0] < floor))
            return floor;
        return d[DATA_W-1:0];
    endfunction

    assign w_step_eff = (i_step == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : i_step;

    vco_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_accept),
        .i_value  (i_dwell),
        .i_enable (r_state == ST_RUN),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Stop beats start: a simultaneous stop suppresses both the
                // start and the range error.
                if (i_start && !i_stop) begin
                    if (i_lo <= i_hi) begin
                        w_accept     = 1'b1;
                        w_data_next  = i_lo;
                        w_valid_next = 1'b1;
                        w_dir_next   = DIR_UP;
                        w_state_next = (i_mode == MODE_HOLD) ? ST_HOLD : ST_RUN;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (i_stop) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick) begin
                    if (r_dir == DIR_UP) begin
                        if (r_data < r_hi) begin
                            w_data_next  = sat_add(r_data, r_step, r_hi);
                            w_valid_next = 1'b1;
                        end else begin
                            case (r_mode)
                                MODE_RAMP_ONCE: begin
                                    w_done_next  = 1'b1;
                                    w_state_next = ST_IDLE;
                                end
                                MODE_RAMP_LOOP: begin
                                    w_data_next  = r_lo;
                                    w_valid_next = 1'b1;
                                end
                                default: begin
                                    w_dir_next   = DIR_DOWN;
                                    w_data_next  = sat_sub(r_hi, r_step, r_lo);
                                    w_valid_next = 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        // Only the triangle mode ever turns downwards.
                        if (r_data > r_lo) begin
                            w_data_next = sat_sub(r_data, r_step, r_lo);
                        end else begin
                            w_dir_next  = DIR_UP;
                            w_data_next = sat_add(r_lo, r_step, r_hi);
                        end
                        w_valid_next = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (i_stop)
                    w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_UP;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_mode  <= MODE_HOLD;
            r_lo    <= '0;
            r_hi    <= '0;
            r_step  <= '0;
        end else begin
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            if (w_accept) begin
                r_mode <= i_mode;
                r_lo   <= i_lo;
                r_hi   <= i_hi;
                r_step <= w_step_eff;
            end
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_vco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vco_sweep_ctrl
// Self-checking bench for vco_sweep_ctrl. A behavioural model expands each
// accepted start into a per-cycle trace of expected outputs; a compare
// process checks the DUT against it every cycle, and directed literal
// expectations pin key points of each scenario.
// -----------------------------------------------------------------------------
module tb_vco_sweep_ctrl;
    import vco_sweep_pkg::*;

    localparam int DW = 8;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          i_reset, i_start, i_stop;
    logic [1:0]    i_mode;
    logic [DW-1:0] i_lo, i_hi, i_step;
    logic [TW-1:0] i_dwell;
    logic [DW-1:0] o_data;
    logic          o_data_valid, o_busy, o_done, o_err;

    always #5 clk = ~clk;

    vco_sweep_ctrl #(
        .DWELL_W (TW),
        .DATA_W  (DW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_mode       (i_mode),
        .i_lo         (i_lo),
        .i_hi         (i_hi),
        .i_step       (i_step),
        .i_dwell      (i_dwell),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t cur;
    exp_t trace_q[$];
    bit   model_on = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Expected per-cycle outputs of one sweep, from the sweep rules directly.
    task automatic build_trace(input int mode, input int lo, input int hi,
                               input int step, input int dwell);
        int   v;
        int   s;
        bit   up;
        exp_t e;
        trace_q.delete();
        v  = lo;
        up = 1'b1;
        s  = (step == 0) ? 1 : step;
        while (trace_q.size() < 400) begin
            for (int k = 0; k <= dwell; k++) begin
                e.data = 8'(v); e.valid = (k == 0); e.busy = 1'b1;
                e.done = 1'b0;  e.err = 1'b0;
                trace_q.push_back(e);
            end
            if (mode == 0) break;
            if (up) begin
                if (v < hi) begin
                    v = (v + s > hi) ? hi : v + s;
                end else if (mode == 1) begin
                    e.data = 8'(hi); e.valid = 1'b0; e.busy = 1'b0;
                    e.done = 1'b1;   e.err = 1'b0;
                    trace_q.push_back(e);
                    break;
                end else if (mode == 2) begin
                    v = lo;
                end else begin
                    up = 1'b0;
                    v  = (hi - s < lo) ? lo : hi - s;
                end
            end else begin
                if (v > lo) begin
                    v = (v - s < lo) ? lo : v - s;
                end else begin
                    up = 1'b1;
                    v  = (lo + s > hi) ? hi : lo + s;
                end
            end
        end
    endtask

    // Model update: what the outputs must be after this edge.
    always @(posedge clk) begin
        if (i_reset) begin
            cur.data = 8'd0; cur.valid = 1'b0; cur.busy = 1'b0;
            cur.done = 1'b0; cur.err = 1'b0;
            trace_q.delete();
            model_on = 1'b1;
        end else begin
            cur.err = 1'b0;
            if (cur.busy) begin
                if (i_stop) begin
                    cur.busy = 1'b0; cur.valid = 1'b0; cur.done = 1'b0;
                    trace_q.delete();
                end else if (trace_q.size() > 0) begin
                    cur = trace_q.pop_front();
                end else begin
                    cur.valid = 1'b0; cur.done = 1'b0;
                end
            end else begin
                cur.valid = 1'b0; cur.done = 1'b0;
                if (i_start && !i_stop) begin
                    if (i_lo <= i_hi) begin
                        build_trace(int'(i_mode), int'(i_lo), int'(i_hi),
                                    int'(i_step), int'(i_dwell));
                        cur = trace_q.pop_front();
                    end else begin
                        cur.err = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            checks++;
            if (o_data !== cur.data || o_data_valid !== cur.valid || o_busy !== cur.busy ||
                o_done !== cur.done || o_err !== cur.err) begin
                errors++;
                $display("FAIL model_cmp t=%0t got data=%0d v=%b b=%b d=%b e=%b want data=%0d v=%b b=%b d=%b e=%b",
                         $time, o_data, o_data_valid, o_busy, o_done, o_err,
                         cur.data, cur.valid, cur.busy, cur.done, cur.err);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Drives a start in "cycle 0"; returns early in cycle 1.
    task automatic start_sweep(input logic [1:0] mode, input logic [7:0] lo,
                               input logic [7:0] hi, input logic [7:0] step,
                               input int dwell, input logic with_stop);
        @(posedge clk); #1;
        i_mode = mode; i_lo = lo; i_hi = hi; i_step = step;
        i_dwell = TW'(dwell); i_start = 1'b1; i_stop = with_stop;
        @(posedge clk); #1;
        i_start = 1'b0; i_stop = 1'b0;
    endtask

    task automatic do_stop();
        @(posedge clk); #1 i_stop = 1'b1;
        @(posedge clk); #1 i_stop = 1'b0;
    endtask

    int exp1[10] = '{10, 10, 14, 14, 18, 18, 20, 20, 20, 20};
    int exp2[7]  = '{250, 254, 255, 251, 250, 254, 255};

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_mode = 2'b00;
        i_lo = '0; i_hi = '0; i_step = '0; i_dwell = '0;
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        chk("reset_data", int'(o_data), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_valid", int'(o_data_valid), 0);

        // Single ramp 10..20 step 4, two cycles per value.
        start_sweep(MODE_RAMP_ONCE, 8'd10, 8'd20, 8'd4, 1, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("ramp_once_data", int'(o_data), exp1[c-1]);
            chk("ramp_once_done", int'(o_done), int'(c == 9));
            chk("ramp_once_busy", int'(o_busy), int'(c < 9));
        end

        // Triangle near the top of the range: no 8-bit wrap.
        start_sweep(MODE_TRIANGLE, 8'd250, 8'd255, 8'd4, 0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("tri_data", int'(o_data), exp2[c-1]);
            chk("tri_valid", int'(o_data_valid), 1);
        end
        do_stop();
        @(negedge clk);
        chk("tri_stop_data", int'(o_data), exp2[6]);
        chk("tri_stop_busy", int'(o_busy), 0);
        chk("tri_stop_valid", int'(o_data_valid), 0);

        // Rejected start, then the same with stop asserted.
        start_sweep(MODE_RAMP_LOOP, 8'd30, 8'd20, 8'd1, 0, 1'b0);
        @(negedge clk);
        chk("err_pulse", int'(o_err), 1);
        chk("err_busy", int'(o_busy), 0);
        chk("err_data", int'(o_data), 255);
        @(negedge clk);
        chk("err_clear", int'(o_err), 0);
        start_sweep(MODE_RAMP_LOOP, 8'd30, 8'd20, 8'd1, 0, 1'b1);
        @(negedge clk);
        chk("err_stop_wins", int'(o_err), 0);

        // Hold mode, then stop.
        start_sweep(MODE_HOLD, 8'h5A, 8'h80, 8'd3, 0, 1'b0);
        @(negedge clk);
        chk("hold_data", int'(o_data), 'h5A);
        chk("hold_busy", int'(o_busy), 1);
        repeat (99) @(negedge clk);
        do_stop();
        @(negedge clk);
        chk("hold_stop_busy", int'(o_busy), 0);
        chk("hold_stop_done", int'(o_done), 0);
        chk("hold_stop_data", int'(o_data), 'h5A);

        // Looping ramp 0..8 with step 0 (treated as 1), three cycles per value.
        start_sweep(MODE_RAMP_LOOP, 8'd0, 8'd8, 8'd0, 2, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            chk("loop_busy", int'(o_busy), 1);
            if (c == 1)  chk("loop_c1", int'(o_data), 0);
            if (c == 4)  chk("loop_c4", int'(o_data), 1);
            if (c == 25) chk("loop_c25", int'(o_data), 8);
            if (c == 27) chk("loop_c27", int'(o_data), 8);
            if (c == 28) chk("loop_wrap", int'(o_data), 0);
            if (c == 28) chk("loop_wrap_valid", int'(o_data_valid), 1);
            if (c == 29) chk("loop_c29_valid", int'(o_data_valid), 0);
        end
        @(posedge clk); #1 i_reset = 1'b1;
        @(posedge clk); #1 i_reset = 1'b0;
        @(negedge clk);
        chk("midreset_data", int'(o_data), 0);
        chk("midreset_busy", int'(o_busy), 0);
        chk("midreset_valid", int'(o_data_valid), 0);

        // Start while busy is ignored.
        start_sweep(MODE_RAMP_LOOP, 8'd5, 8'd9, 8'd1, 3, 1'b0);
        repeat (5) @(negedge clk);
        start_sweep(MODE_HOLD, 8'd100, 8'd200, 8'd1, 0, 1'b0);
        @(negedge clk);
        chk("busy_start_data", int'(o_data), 6);
        chk("busy_start_busy", int'(o_busy), 1);
        repeat (2) @(negedge clk);
        chk("busy_start_next", int'(o_data), 7);
        do_stop();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
